mux_rr_sched: RTL and testbench
===============================

Name: mux_rr_sched

Overview:
- Round-robin scheduler that shares the 32:1, 2-bit selection mux between 32 requesters.
- Arbitrates requests and drives the mux `sel` from a register.
- Captures the selected 2-bit mux output into a registered result with a valid/ready handshake, then pulses a per-requester acknowledge.
- Sits between the requesters and the mux datapath; the mux stays purely combinational.

Parameters:
- N_IN, 32, number of requesters (power of two, 2..32).
- SEL_W, 5, select width; must equal log2(N_IN).
- DATA_W, 2, width of mux data path.

Ports:
- clk  input  1  clock; all flops rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_IN  per-requester request, level-sensitive.
- en_mask  input  N_IN  1 = requester eligible; sampled every cycle.
- sel  output  SEL_W  registered select driven to the mux.
- mux_out  input  DATA_W  combinational mux output for current sel.
- out_data  output  DATA_W  captured data.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- out_idx  output  SEL_W  index that produced out_data.
- ack  output  N_IN  one-hot, one-cycle pulse to the served requester.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release) values:
  - sel=0, out_data=0, out_valid=0, out_idx=0, ack=0, busy=0.
  - state=IDLE, last_grant=N_IN-1, so the first search starts at index 0.
- eligible = req & en_mask.
- State IDLE:
  - If eligible != 0, pick the first set bit scanning upward from last_grant+1, wrapping modulo N_IN.
  - Register sel = pick, go to SETTLE.
  - Else stay; sel holds its last value.
- State SETTLE (exactly 1 cycle, lets the mux output settle on the registered sel):
  - Next edge: out_data = mux_out, out_idx = sel, out_valid = 1, go to HOLD.
  - The grant is committed: req or en_mask dropping during SETTLE does not abort.
- State HOLD:
  - out_valid=1; out_data, out_idx and sel are held stable.
  - On out_valid & out_ready at an edge:
    - out_valid = 0.
    - ack[out_idx] = 1 for the next cycle only.
    - last_grant = out_idx.
    - Go to IDLE.
- Latency and throughput:
  - eligible seen in IDLE at edge N → sel valid after N → out_valid after N+1.
  - With out_ready tied high, one grant every 3 cycles: IDLE→SETTLE→HOLD→IDLE.
  - out_ready asserted while not in HOLD is ignored.
- Fairness: a continuously requesting index is served within N_IN grants. The just-served index has lowest priority in the next search.
- Single requester: it is re-granted repeatedly; wrap from 31 to 0 is legal.
- All eligible bits clear: stay IDLE, busy=0, no ack.
- Simultaneous events:
  - A new request arriving in HOLD is considered only in the next IDLE.
  - ack coincides with the IDLE cycle. The requester must drop req in that cycle, or it is eligible again (and is lowest priority).
- rst_n asserted mid-operation: immediately returns to reset values. No ack is issued for the aborted grant.
- Combinational paths: none from inputs to outputs. All outputs are registered.

Decomposition:
- Shared package mux_sched_pkg:
  - state enum (IDLE, SETTLE, HOLD).
  - constants N_IN=32, SEL_W=5, DATA_W=2.
- Sub-module rr_pick: purely combinational rotating priority encoder.
  - Inputs: eligible[N_IN], last_grant[SEL_W].
  - Outputs: pick[SEL_W], any.
  - Implementation: double-width mask-and-find-first.

Test Plan:
- Reset, then req=0x0000_1000, en_mask all 1, mux returns 2'b10 for sel=12 → sel=12 one cycle after req, out_valid one cycle later with out_data=2'b10, out_idx=12. With out_ready=1: ack=0x0000_1000 pulse, last_grant=12.
- req=0xFFFF_FFFF, out_ready=1 held for 33 grants → out_idx sequence 0,1,2,…,31,0; each ack exactly one-hot.
- Grant in HOLD with out_ready=0 for 5 cycles → out_valid, out_data, sel stable; no ack. Raise out_ready → single ack, return to IDLE.
- req=0x8000_0001 with last_grant=31 → grant 0, then 31, then 0; wrap behaviour correct.
- req=0x0000_00F0, en_mask=0x0000_0030 → only indices 4,5 granted, alternating; masking index 5 mid-HOLD does not disturb the current transfer.
- Assert rst_n=0 during SETTLE of a grant to index 7 → outputs return to 0 immediately, no ack[7]. After release with req[3] set, first grant is index 3.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared types and sizing for the round-robin mux scheduler.
package mux_sched_pkg;

  localparam int N_IN   = 32;
  localparam int SEL_W  = 5;
  localparam int DATA_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first eligible index above last_grant,
// wrapping modulo N_IN.
module rr_pick #(
  parameter int N_IN  = mux_sched_pkg::N_IN,
  parameter int SEL_W = mux_sched_pkg::SEL_W
) (
  input  logic [N_IN-1:0]  eligible,
  input  logic [SEL_W-1:0] last_grant,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  logic [2*N_IN-1:0] dbl;
  logic [2*N_IN-1:0] hi;
  logic [2*N_IN-1:0] masked;

  assign dbl    = {eligible, eligible};
  assign masked = dbl & hi;
  assign any    = |eligible;

  always_comb begin
    hi = '0;
    for (int i = 0; i < 2*N_IN; i++) begin
      hi[i] = (i > int'(last_grant));
    end
  end

  // Downward scan so the lowest masked index is the one left standing.
  always_comb begin
    pick = '0;
    for (int i = 2*N_IN-1; i >= 0; i--) begin
      if (masked[i]) begin
        pick = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin owner of a shared N:1 mux: registers sel, captures the
// settled mux output and acknowledges the served requester.
module mux_rr_sched #(
  parameter int N_IN   = mux_sched_pkg::N_IN,
  parameter int SEL_W  = mux_sched_pkg::SEL_W,
  parameter int DATA_W = mux_sched_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   req,
  input  logic [N_IN-1:0]   en_mask,
  output logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] mux_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_idx,
  output logic [N_IN-1:0]   ack,
  output logic              busy
);
  import mux_sched_pkg::*;

  state_t           state;
  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] pick;
  logic             any;

  rr_pick #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_pick (
    .eligible   (req & en_mask),
    .last_grant (last_grant),
    .pick       (pick),
    .any        (any)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= SEL_W'(N_IN-1);
      sel        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      ack        <= '0;
    end else begin
      ack <= '0;
      unique case (state)
        IDLE: begin
          if (any) begin
            sel   <= pick;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          out_data  <= mux_out;
          out_idx   <= sel;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid    <= 1'b0;
            ack[out_idx] <= 1'b1;
            last_grant   <= out_idx;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed bench for mux_rr_sched with a modelled 32:1 mux datapath.
module tb_mux_rr_sched;

  logic        clk;
  logic        rst_n;
  logic [31:0] req;
  logic [31:0] en_mask;
  logic [4:0]  sel;
  logic [1:0]  mux_out;
  logic [1:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [31:0] ack;
  logic        busy;

  int checks;
  int failures;

  mux_rr_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .en_mask   (en_mask),
    .sel       (sel),
    .mux_out   (mux_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .ack       (ack),
    .busy      (busy)
  );

  function automatic logic [1:0] mux_fn(input logic [4:0] s);
    logic [6:0] t;
    t = {2'b00, s};
    t = t * 7'd3 + 7'd2;
    return t[1:0];
  endfunction

  assign mux_out = mux_fn(sel);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    en_mask = '1;
    out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (sel !== 5'd0 || out_data !== 2'd0 || out_valid !== 1'b0 ||
        out_idx !== 5'd0 || ack !== 32'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset: sel=%0d data=%0d v=%0b idx=%0d ack=%h busy=%0b want all 0",
               sel, out_data, out_valid, out_idx, ack, busy);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || ack !== 32'd0) begin
      failures++;
      $display("FAIL idle_no_req: busy=%0b ack=%h want 0/0", busy, ack);
    end
  endtask

  task automatic test_single();
    req = 32'h0000_1000;
    out_ready = 1'b1;
    tick();
    checks++;
    if (sel !== 5'd12 || out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_sel: sel=%0d v=%0b busy=%0b want 12/0/1", sel, out_valid, busy);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 2'b10 || out_idx !== 5'd12) begin
      failures++;
      $display("FAIL single_out: v=%0b data=%0d idx=%0d want 1/2/12",
               out_valid, out_data, out_idx);
    end
    tick();
    req = '0;
    checks++;
    if (ack !== 32'h0000_1000 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_ack: ack=%h v=%0b busy=%0b want 00001000/0/0", ack, out_valid, busy);
    end
    tick();
    checks++;
    if (ack !== 32'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_ack_pulse: ack=%h busy=%0b want 0/0", ack, busy);
    end
  endtask

  task automatic test_sweep();
    logic [4:0] e;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req = '1;
    out_ready = 1'b1;
    for (int k = 0; k < 33; k++) begin
      e = 5'(k % 32);
      tick();
      checks++;
      if (sel !== e) begin
        failures++;
        $display("FAIL sweep_sel[%0d]: sel=%0d want %0d", k, sel, e);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_idx !== e || out_data !== mux_fn(e)) begin
        failures++;
        $display("FAIL sweep_out[%0d]: v=%0b idx=%0d data=%0d want 1/%0d/%0d",
                 k, out_valid, out_idx, out_data, e, mux_fn(e));
      end
      tick();
      if (k == 32) req = '0;
      checks++;
      if (ack !== (32'd1 << e)) begin
        failures++;
        $display("FAIL sweep_ack[%0d]: ack=%h want %h", k, ack, 32'd1 << e);
      end
    end
    tick();
  endtask

  task automatic test_hold_stall();
    req = 32'h0000_0200;
    out_ready = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== mux_fn(5'd9) || sel !== 5'd9 ||
          out_idx !== 5'd9 || ack !== 32'd0) begin
        failures++;
        $display("FAIL stall[%0d]: v=%0b data=%0d sel=%0d idx=%0d ack=%h want 1/%0d/9/9/0",
                 k, out_valid, out_data, sel, out_idx, ack, mux_fn(5'd9));
      end
    end
    out_ready = 1'b1;
    tick();
    req = '0;
    checks++;
    if (ack !== 32'h0000_0200 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: ack=%h v=%0b want 00000200/0", ack, out_valid);
    end
    tick();
    checks++;
    if (ack !== 32'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_single_ack: ack=%h busy=%0b want 0/0", ack, busy);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] exp_q [3];
    exp_q = '{5'd0, 5'd31, 5'd0};
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req = 32'h8000_0001;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_idx !== exp_q[k]) begin
        failures++;
        $display("FAIL wrap[%0d]: v=%0b idx=%0d want 1/%0d", k, out_valid, out_idx, exp_q[k]);
      end
      tick();
      if (k == 2) req = '0;
      checks++;
      if (ack !== (32'd1 << exp_q[k])) begin
        failures++;
        $display("FAIL wrap_ack[%0d]: ack=%h want %h", k, ack, 32'd1 << exp_q[k]);
      end
    end
    tick();
  endtask

  task automatic test_mask();
    logic [4:0] exp_q [3];
    exp_q = '{5'd4, 5'd5, 5'd4};
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req = 32'h0000_00F0;
    en_mask = 32'h0000_0030;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tick();
      checks++;
      if (out_idx !== exp_q[k]) begin
        failures++;
        $display("FAIL mask[%0d]: idx=%0d want %0d", k, out_idx, exp_q[k]);
      end
      tick();
    end
    out_ready = 1'b0;
    tick();
    tick();
    en_mask = 32'h0000_0010;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 5'd5 || out_data !== mux_fn(5'd5) || ack !== 32'd0) begin
      failures++;
      $display("FAIL mask_hold: v=%0b idx=%0d data=%0d ack=%h want 1/5/%0d/0",
               out_valid, out_idx, out_data, ack, mux_fn(5'd5));
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (ack !== 32'h0000_0020) begin
      failures++;
      $display("FAIL mask_ack: ack=%h want 00000020", ack);
    end
    tick();
    req = '0;
    en_mask = '1;
    checks++;
    if (sel !== 5'd4) begin
      failures++;
      $display("FAIL mask_next: sel=%0d want 4", sel);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    req = 32'h0000_0080;
    out_ready = 1'b0;
    tick();
    checks++;
    if (sel !== 5'd7 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_settle: sel=%0d busy=%0b want 7/1", sel, busy);
    end
    rst_n = 1'b0;
    req = '0;
    #1;
    checks++;
    if (sel !== 5'd0 || out_valid !== 1'b0 || busy !== 1'b0 || ack !== 32'd0 ||
        out_idx !== 5'd0 || out_data !== 2'd0) begin
      failures++;
      $display("FAIL abort_async: sel=%0d v=%0b busy=%0b ack=%h idx=%0d data=%0d want 0s",
               sel, out_valid, busy, ack, out_idx, out_data);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (ack !== 32'd0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL abort_noack[%0d]: ack=%h v=%0b want 0/0", k, ack, out_valid);
      end
    end
    rst_n = 1'b1;
    req = 32'h0000_0008;
    out_ready = 1'b1;
    tick();
    checks++;
    if (sel !== 5'd3) begin
      failures++;
      $display("FAIL abort_regrant_sel: sel=%0d want 3", sel);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 5'd3) begin
      failures++;
      $display("FAIL abort_regrant_out: v=%0b idx=%0d want 1/3", out_valid, out_idx);
    end
    tick();
    req = '0;
    checks++;
    if (ack !== 32'h0000_0008) begin
      failures++;
      $display("FAIL abort_regrant_ack: ack=%h want 00000008", ack);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req = '0;
    en_mask = '1;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_sweep();
    test_hold_stall();
    test_wrap();
    test_mask();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
